// File: rtl/prescaled_compare_counter.sv
// Prescaled up/down counter with compare channels.
// A prescaler divides the clock into count ticks. The counter runs from an
// initial value to a terminal value, then pulses overflow and either reloads
// or returns to IDLE. Each compare channel pulses when the counter is loaded
// or stepped onto that channel's value.
module prescaled_compare_counter #(
    parameter int bitwidth              = 8,
    parameter int prescaler_width       = 4,
    parameter int channels              = 2,
    parameter bit start_resets_counting = 1'b0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         autoreload,
    input  logic                         count_down,
    input  logic [bitwidth-1:0]          reload_value,
    input  logic [prescaler_width-1:0]   prescaler_value,
    input  logic [channels*bitwidth-1:0] compare_values,
    output logic [bitwidth-1:0]          counter_value,
    output logic                         running,
    output logic                         overflow,
    output logic [channels-1:0]          compare_match
);

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_stateNext;
    logic [bitwidth-1:0]          r_counter;
    logic [bitwidth-1:0]          w_countNext;
    logic [prescaler_width-1:0]   r_prescaler;
    logic [prescaler_width-1:0]   w_prescNext;
    logic                         r_direction;
    logic                         w_dirNext;
    logic                         r_overflow;
    logic                         w_ovfNext;
    logic [channels-1:0]          r_match;
    logic [channels-1:0]          w_matchNext;
    logic                         w_load;
    logic                         w_tick;
    logic                         w_atTerminal;
    logic [bitwidth-1:0]          w_runInitial;
    logic [bitwidth-1:0]          w_startInitial;

    // Tick detection, terminal detection and the two flavours of initial value.
    // The tick uses >= so that lowering prescaler_value below the current
    // prescaler count produces a tick instead of a long wrap-around stall, and
    // an up count already above a lowered reload_value is treated as terminal.
    always_comb begin
        w_tick         = (r_state == RUNNING) && (r_prescaler >= prescaler_value);
        w_atTerminal   = r_direction ? (r_counter == '0) : (r_counter >= reload_value);
        w_runInitial   = r_direction ? reload_value : '0;
        w_startInitial = count_down ? reload_value : '0;
    end

    // Next-state and datapath decisions; stop outranks start, and start
    // (when restarting is enabled) outranks a tick on the same clock.
    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_counter;
        w_prescNext = r_prescaler;
        w_dirNext   = r_direction;
        w_ovfNext   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_prescNext = '0;
                if (start && !stop) begin
                    w_stateNext = RUNNING;
                    w_dirNext   = count_down;
                    w_countNext = w_startInitial;
                    w_load      = 1'b1;
                end
            end
            RUNNING: begin
                if (stop) begin
                    w_stateNext = IDLE;
                    w_prescNext = '0;
                end else if (start && start_resets_counting) begin
                    w_dirNext   = count_down;
                    w_countNext = w_startInitial;
                    w_prescNext = '0;
                    w_load      = 1'b1;
                end else if (w_tick) begin
                    w_prescNext = '0;
                    if (w_atTerminal) begin
                        w_ovfNext = 1'b1;
                        if (autoreload) begin
                            w_countNext = w_runInitial;
                            w_load      = 1'b1;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_countNext = r_direction ? (r_counter - bitwidth'(1))
                                                  : (r_counter + bitwidth'(1));
                        w_load      = 1'b1;
                    end
                end else begin
                    w_prescNext = r_prescaler + prescaler_width'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // A channel matches only when the counter is written this clock, so a
    // held value never re-asserts its match.
    always_comb begin
        w_matchNext = '0;
        for (int i = 0; i < channels; i++) begin
            w_matchNext[i] = w_load && (w_countNext == compare_values[i*bitwidth +: bitwidth]);
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Counter, prescaler, direction and the registered pulse outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_counter   <= '0;
            r_prescaler <= '0;
            r_direction <= 1'b0;
            r_overflow  <= 1'b0;
            r_match     <= '0;
        end else begin
            r_counter   <= w_countNext;
            r_prescaler <= w_prescNext;
            r_direction <= w_dirNext;
            r_overflow  <= w_ovfNext;
            r_match     <= w_matchNext;
        end
    end

    assign counter_value = r_counter;
    assign running       = (r_state == RUNNING);
    assign overflow      = r_overflow;
    assign compare_match = r_match;

endmodule

// File: tb/tb_prescaled_compare_counter.sv
// Self-checking bench for prescaled_compare_counter: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a model.
module tb_prescaled_compare_counter;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic        autoreload;
    logic        count_down;
    logic [7:0]  reloadValue;
    logic [3:0]  prescValue;
    logic [15:0] cmpValues;
    logic [7:0]  cntA;
    logic        runA;
    logic        ovfA;
    logic [1:0]  matchA;
    logic [7:0]  cntB;
    logic        runB;
    logic        ovfB;
    logic [1:0]  matchB;

    int nChecks = 0;
    int nFails  = 0;

    // Default instance: start while running is ignored.
    prescaled_compare_counter #(
        .bitwidth(8), .prescaler_width(4), .channels(2), .start_resets_counting(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .autoreload(autoreload), .count_down(count_down),
        .reload_value(reloadValue), .prescaler_value(prescValue),
        .compare_values(cmpValues), .counter_value(cntA), .running(runA),
        .overflow(ovfA), .compare_match(matchA)
    );

    // Second instance: start while running restarts the count.
    prescaled_compare_counter #(
        .bitwidth(8), .prescaler_width(4), .channels(2), .start_resets_counting(1'b1)
    ) dutR (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .autoreload(autoreload), .count_down(count_down),
        .reload_value(reloadValue), .prescaler_value(prescValue),
        .compare_values(cmpValues), .counter_value(cntB), .running(runB),
        .overflow(ovfB), .compare_match(matchB)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic       st;
        logic       sp;
        logic       ar;
        logic       cd;
        logic [7:0] rv;
        logic [7:0] expCnt;
        logic       expRun;
        logic       expOvf;
        logic [1:0] expMatch;
    } vec_t;

    // Reference behaviour: what the counter should look like after one clock.
    typedef struct {
        bit       run;
        bit       down;
        int       count;
        int       phase;
        bit       ovf;
        bit [1:0] match;
    } model_t;

    vec_t   vecs[$];
    model_t mA;
    model_t mB;

    function automatic vec_t mk(logic st, logic sp, logic ar, logic cd, logic [7:0] rv,
                                logic [7:0] c, logic r, logic o, logic [1:0] m);
        vec_t v;
        v.st = st; v.sp = sp; v.ar = ar; v.cd = cd; v.rv = rv;
        v.expCnt = c; v.expRun = r; v.expOvf = o; v.expMatch = m;
        return v;
    endfunction

    function automatic model_t modelStep(model_t s, bit restartOk, bit st, bit sp, bit ar,
                                         bit cd, int rv, int pv, int c0, int c1);
        model_t n;
        bit     written;
        n       = s;
        n.ovf   = 1'b0;
        n.match = 2'b00;
        written = 1'b0;
        if (!s.run) begin
            n.phase = 0;
            if (st && !sp) begin
                n.run   = 1'b1;
                n.down  = cd;
                n.count = cd ? rv : 0;
                written = 1'b1;
            end
        end else if (sp) begin
            n.run   = 1'b0;
            n.phase = 0;
        end else if (st && restartOk) begin
            n.down  = cd;
            n.count = cd ? rv : 0;
            n.phase = 0;
            written = 1'b1;
        end else if (s.phase >= pv) begin
            n.phase = 0;
            if ((s.down && s.count == 0) || (!s.down && s.count >= rv)) begin
                n.ovf = 1'b1;
                if (ar) begin
                    n.count = s.down ? rv : 0;
                    written = 1'b1;
                end else begin
                    n.run = 1'b0;
                end
            end else begin
                n.count = s.down ? s.count - 1 : s.count + 1;
                written = 1'b1;
            end
        end else begin
            n.phase = s.phase + 1;
        end
        if (written) begin
            n.match[0] = (n.count == c0);
            n.match[1] = (n.count == c1);
        end
        return n;
    endfunction

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(logic st, logic sp, logic ar, logic cd, logic [7:0] rv,
                                 logic [3:0] pv);
        start       = st;
        stop        = sp;
        autoreload  = ar;
        count_down  = cd;
        reloadValue = rv;
        prescValue  = pv;
    endtask

    task automatic checkOutput(string name, bit useR, logic [7:0] expCnt, logic expRun,
                               logic expOvf, logic [1:0] expMatch);
        logic [11:0] act;
        logic [11:0] exp;
        act = useR ? {cntB, runB, ovfB, matchB} : {cntA, runA, ovfA, matchA};
        exp = {expCnt, expRun, expOvf, expMatch};
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got cnt=%0d run=%b ovf=%b match=%b, expected cnt=%0d run=%b ovf=%b match=%b",
                     name, act[11:4], act[3], act[2], act[1:0],
                     exp[11:4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        cmpValues = 16'd0;

        // Reset state.
        doReset();
        checkOutput("reset_state", 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
        checkOutput("reset_state_r", 1'b1, 8'd0, 1'b0, 1'b0, 2'b00);

        // Directed table, prescaler 0, channel compares {ch1=3, ch0=1}.
        //             st sp ar cd  rv     cnt r  o  match
        vecs.push_back(mk(1, 0, 0, 0, 8'd3, 8'd0, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, 0, 8'd3, 8'd1, 1, 0, 2'b01));
        vecs.push_back(mk(0, 0, 0, 0, 8'd3, 8'd2, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, 0, 8'd3, 8'd3, 1, 0, 2'b10));
        vecs.push_back(mk(0, 0, 0, 0, 8'd3, 8'd3, 0, 1, 2'b00));
        vecs.push_back(mk(0, 0, 0, 0, 8'd3, 8'd3, 0, 0, 2'b00));
        vecs.push_back(mk(1, 0, 1, 0, 8'd3, 8'd0, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 1, 0, 8'd3, 8'd1, 1, 0, 2'b01));
        vecs.push_back(mk(0, 0, 1, 0, 8'd3, 8'd2, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 1, 0, 8'd3, 8'd3, 1, 0, 2'b10));
        vecs.push_back(mk(0, 0, 1, 0, 8'd3, 8'd0, 1, 1, 2'b00));
        vecs.push_back(mk(0, 0, 1, 0, 8'd3, 8'd1, 1, 0, 2'b01));
        vecs.push_back(mk(0, 1, 1, 0, 8'd3, 8'd1, 0, 0, 2'b00));
        vecs.push_back(mk(1, 1, 0, 0, 8'd3, 8'd1, 0, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, 0, 8'd3, 8'd1, 0, 0, 2'b00));
        vecs.push_back(mk(1, 0, 0, 1, 8'd5, 8'd5, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 8'd4, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, 1, 8'd5, 8'd3, 1, 0, 2'b10));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 8'd2, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, 1, 8'd5, 8'd1, 1, 0, 2'b01));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 8'd0, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 8'd0, 0, 1, 2'b00));
        vecs.push_back(mk(1, 0, 1, 0, 8'd0, 8'd0, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 8'd0, 1, 1, 2'b00));
        vecs.push_back(mk(0, 0, 1, 0, 8'd0, 8'd0, 1, 1, 2'b00));
        vecs.push_back(mk(0, 1, 1, 0, 8'd0, 8'd0, 0, 0, 2'b00));

        cmpValues = {8'd3, 8'd1};
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].st, vecs[k].sp, vecs[k].ar, vecs[k].cd, vecs[k].rv, 4'd0);
            advance();
            checkOutput($sformatf("table_%0d", k), 1'b0, vecs[k].expCnt, vecs[k].expRun,
                        vecs[k].expOvf, vecs[k].expMatch);
        end

        // Prescaler 2, reload 12: each value held three clocks, start held for ten.
        doReset();
        cmpValues = {8'd7, 8'd4};
        for (int k = 0; k <= 40; k++) begin
            applyStimulus((k < 10), 1'b0, 1'b0, 1'b0, 8'd12, 4'd2);
            advance();
            if (k <= 38) begin
                logic [7:0] c;
                c = 8'(k / 3);
                checkOutput($sformatf("presc_k%0d", k), 1'b0, c, 1'b1, 1'b0,
                            ((k % 3) == 0) ? {c == 8'd7, c == 8'd4} : 2'b00);
            end else begin
                checkOutput($sformatf("presc_k%0d", k), 1'b0, 8'd12, 1'b0, (k == 39), 2'b00);
            end
        end

        // Compare channels {2,2}, restart re-arms the matches on the restarting instance.
        doReset();
        cmpValues = {8'd2, 8'd2};
        for (int k = 0; k <= 8; k++) begin
            applyStimulus((k == 0) || (k == 5), 1'b0, 1'b0, 1'b0, 8'd5, 4'd0);
            advance();
            case (k)
                0: checkOutput("restart_k0", 1'b1, 8'd0, 1'b1, 1'b0, 2'b00);
                2: checkOutput("restart_k2", 1'b1, 8'd2, 1'b1, 1'b0, 2'b11);
                4: checkOutput("restart_k4", 1'b1, 8'd4, 1'b1, 1'b0, 2'b00);
                5: begin
                    checkOutput("restart_k5", 1'b1, 8'd0, 1'b1, 1'b0, 2'b00);
                    checkOutput("noRestart_k5", 1'b0, 8'd5, 1'b1, 1'b0, 2'b00);
                end
                7: checkOutput("restart_k7", 1'b1, 8'd2, 1'b1, 1'b0, 2'b11);
                8: checkOutput("restart_k8", 1'b1, 8'd3, 1'b1, 1'b0, 2'b00);
                default: ;
            endcase
        end

        // Stop on the terminal tick suppresses the overflow.
        doReset();
        cmpValues = {8'd9, 8'd9};
        for (int k = 0; k <= 4; k++) begin
            applyStimulus((k == 0), (k == 3), 1'b0, 1'b0, 8'd2, 4'd0);
            advance();
            if (k == 2) checkOutput("stopTerm_k2", 1'b0, 8'd2, 1'b1, 1'b0, 2'b00);
            if (k >= 3) checkOutput($sformatf("stopTerm_k%0d", k), 1'b0, 8'd2, 1'b0, 1'b0, 2'b00);
        end

        // Asynchronous reset in the middle of a count.
        doReset();
        for (int k = 0; k <= 3; k++) begin
            applyStimulus((k == 0), 1'b0, 1'b0, 1'b0, 8'd10, 4'd0);
            advance();
        end
        checkOutput("preReset", 1'b0, 8'd3, 1'b1, 1'b0, 2'b00);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncReset", 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);
        checkOutput("asyncReset_r", 1'b1, 8'd0, 1'b0, 1'b0, 2'b00);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        advance();
        advance();
        checkOutput("afterReset", 1'b0, 8'd0, 1'b0, 1'b0, 2'b00);

        // Randomized run against the reference model on both instances.
        doReset();
        mA = '{default: 0};
        mB = '{default: 0};
        cmpValues = {8'd4, 8'd2};
        reloadValue = 8'd5;
        prescValue = 4'd1;
        for (int k = 0; k < 1500; k++) begin
            start      = ($urandom_range(7) == 0);
            stop       = ($urandom_range(29) == 0);
            count_down = $urandom_range(1);
            if ($urandom_range(49) == 0) autoreload = ~autoreload;
            if ($urandom_range(39) == 0) reloadValue = 8'($urandom_range(9));
            if ($urandom_range(59) == 0) prescValue = 4'($urandom_range(3));
            if ($urandom_range(39) == 0) cmpValues[7:0] = 8'($urandom_range(9));
            if ($urandom_range(39) == 0) cmpValues[15:8] = 8'($urandom_range(9));
            mA = modelStep(mA, 1'b0, start, stop, autoreload, count_down, int'(reloadValue),
                           int'(prescValue), int'(cmpValues[7:0]), int'(cmpValues[15:8]));
            mB = modelStep(mB, 1'b1, start, stop, autoreload, count_down, int'(reloadValue),
                           int'(prescValue), int'(cmpValues[7:0]), int'(cmpValues[15:8]));
            advance();
            checkOutput($sformatf("rand_%0d", k), 1'b0, 8'(mA.count), mA.run, mA.ovf, mA.match);
            checkOutput($sformatf("randR_%0d", k), 1'b1, 8'(mB.count), mB.run, mB.ovf, mB.match);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
